// File: rtl/enemy_wave_sched_if.sv
// enemy_wave_sched_if: crash/random inputs and per-slot enemy state published by the scheduler.
interface enemy_wave_sched_if #(
  parameter int NUM_SLOTS = 4
);
  logic                      crash;
  logic [9:0]                randint;
  logic [NUM_SLOTS-1:0]      slot_active;
  logic [12*NUM_SLOTS-1:0]   enemy_x;
  logic [12*NUM_SLOTS-1:0]   enemy_y;
  logic                      spawn_pulse;
  logic                      tick;
  logic                      busy;

  modport master (
    input  crash, randint,
    output slot_active, enemy_x, enemy_y, spawn_pulse, tick, busy
  );

  modport slave (
    output crash, randint,
    input  slot_active, enemy_x, enemy_y, spawn_pulse, tick, busy
  );
endinterface

// File: rtl/enemy_wave_sched.sv
// enemy_wave_sched: prescaled movement tick, one-slot-per-cycle shared mover, then one spawn attempt.
// Optional ENEMY_SPEEDUP_EN: X step grows by one every 8 spawns, capped at +4.
module enemy_wave_sched #(
  parameter int NUM_SLOTS = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int SPAWN_GAP = 60,
  parameter int X_START   = 1180,
  parameter int Y_START   = 350,
  parameter int X_MIN     = 30,
  parameter int Y_MIN     = 20,
  parameter int Y_WRAP    = 700,
  parameter int DX        = 3,
  parameter int DY        = 5
) (
  input logic               clk,
  input logic               rst,
  enemy_wave_sched_if.master bus
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_PEN  = PRE_W'(TICK_DIV - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SPAWN_GAP - 1);
  localparam logic [11:0] XS    = 12'(X_START);
  localparam logic [11:0] YS    = 12'(Y_START);
  localparam logic [11:0] XMIN  = 12'(X_MIN);
  localparam logic [11:0] YMIN  = 12'(Y_MIN);
  localparam logic [11:0] YWRAP = 12'(Y_WRAP);
  localparam logic [11:0] DX12  = 12'(DX);
  localparam logic [11:0] DY12  = 12'(DY);

  typedef enum logic [1:0] {S_WAIT, S_UPDATE, S_SPAWN, S_FROZEN} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [PRE_W-1:0]             pre;
  logic [GAP_W-1:0]             gap;
  logic                         tick_q, busy_q, spawn_q;
  logic [NUM_SLOTS-1:0]         act_q;
  logic [NUM_SLOTS-1:0][11:0]   x_q, y_q;

  logic [11:0]      cur_x, cur_y, nxt_x, nxt_y, step, spawn_y;
  logic             cur_act, nxt_act, free_any;
  logic [IDX_W-1:0] free_idx;

`ifdef ENEMY_SPEEDUP_EN
  logic [2:0] tally;
  logic [2:0] extra;
  assign step = DX12 + {9'd0, extra};
`else
  assign step = DX12;
`endif

  // Shared step/wrap datapath, fed by the slot currently selected by idx.
  assign cur_x   = x_q[idx];
  assign cur_y   = y_q[idx];
  assign cur_act = act_q[idx];

  always_comb begin
    nxt_act = cur_act;
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    if (cur_act) begin
      if (cur_x <= XMIN) begin
        nxt_act = 1'b0;
        nxt_x   = XS;
      end else begin
        nxt_x = cur_x - step;
        nxt_y = (cur_y <= YMIN) ? YWRAP : cur_y - DY12;
      end
    end
  end

  // Lowest-index free slot wins the spawn.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign spawn_y = ({2'b00, bus.randint} > YWRAP) ? YWRAP : {2'b00, bus.randint};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_WAIT;
      idx     <= '0;
      pre     <= '0;
      gap     <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      spawn_q <= 1'b0;
      act_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= XS;
        y_q[i] <= YS;
      end
`ifdef ENEMY_SPEEDUP_EN
      tally <= '0;
      extra <= '0;
`endif
    end else if (bus.crash) begin
      // Crash overrides everything; the in-flight slot is not written.
      state   <= S_FROZEN;
      idx     <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      spawn_q <= 1'b0;
      act_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) x_q[i] <= XS;
`ifdef ENEMY_SPEEDUP_EN
      tally <= '0;
      extra <= '0;
`endif
    end else begin
      spawn_q <= 1'b0;
      if (state == S_FROZEN) begin
        state <= S_WAIT;
        pre   <= '0;
        gap   <= '0;
      end else begin
        pre    <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        tick_q <= (pre == PRE_PEN);
        case (state)
          S_WAIT: begin
            if (tick_q) begin
              state  <= S_UPDATE;
              idx    <= '0;
              busy_q <= 1'b1;
            end
          end
          S_UPDATE: begin
            act_q[idx] <= nxt_act;
            x_q[idx]   <= nxt_x;
            y_q[idx]   <= nxt_y;
            if (idx == LAST_IDX) state <= S_SPAWN;
            else                 idx   <= idx + 1'b1;
          end
          S_SPAWN: begin
            state  <= S_WAIT;
            busy_q <= 1'b0;
            // Counter parks at terminal until a slot frees up.
            if (gap != GAP_LAST) begin
              gap <= gap + 1'b1;
            end else if (free_any) begin
              gap             <= '0;
              spawn_q         <= 1'b1;
              act_q[free_idx] <= 1'b1;
              x_q[free_idx]   <= XS;
              y_q[free_idx]   <= spawn_y;
`ifdef ENEMY_SPEEDUP_EN
              tally <= tally + 1'b1;
              if (tally == 3'd7 && extra != 3'd4) extra <= extra + 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.slot_active = act_q;
  assign bus.enemy_x     = x_q;
  assign bus.enemy_y     = y_q;
  assign bus.spawn_pulse = spawn_q;
  assign bus.tick        = tick_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_enemy_wave_sched.sv
// tb_enemy_wave_sched: randomized run of enemy_wave_sched against a per-tick behavioural model.
module tb_enemy_wave_sched;
  localparam int NS = 4, TD = 8, SG = 2;
  localparam int XS = 1180, YS = 350, XMIN = 30, YMIN = 20, YWRAP = 700, DX = 3, DY = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  int m_x[NS];
  int m_y[NS];
  bit m_act[NS];
  int m_gap, m_spawns;

  enemy_wave_sched_if #(.NUM_SLOTS(NS)) bus();

  enemy_wave_sched #(.NUM_SLOTS(NS), .TICK_DIV(TD), .SPAWN_GAP(SG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int m_step();
`ifdef ENEMY_SPEEDUP_EN
    return DX + (((m_spawns / 8) > 4) ? 4 : (m_spawns / 8));
`else
    return DX;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = XS; m_y[i] = YS; m_act[i] = 1'b0;
    end
    m_gap = 0; m_spawns = 0;
  endtask

  task automatic model_slot(input int i);
    if (m_act[i]) begin
      if (m_x[i] <= XMIN) begin
        m_act[i] = 1'b0; m_x[i] = XS;
      end else begin
        m_x[i] = m_x[i] - m_step();
        m_y[i] = (m_y[i] <= YMIN) ? YWRAP : m_y[i] - DY;
      end
    end
  endtask

  task automatic model_freeze();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 1'b0; m_x[i] = XS;
    end
    m_gap = 0; m_spawns = 0;
  endtask

  task automatic model_tick(input int ri, output bit spawned);
    spawned = 1'b0;
    for (int i = 0; i < NS; i++) model_slot(i);
    if (m_gap == SG - 1) begin
      for (int i = 0; i < NS; i++) begin
        if (!m_act[i] && !spawned) begin
          m_act[i] = 1'b1; m_x[i] = XS; m_y[i] = (ri > YWRAP) ? YWRAP : ri;
          spawned = 1'b1;
        end
      end
      if (spawned) begin
        m_gap = 0; m_spawns++;
      end
    end else begin
      m_gap++;
    end
  endtask

  // Waits for the next tick (bounded), advances the model, observes the busy/spawn window.
  task automatic run_tick(input int ri, output int w, output int b, output int p, output bit exp_sp);
    bus.randint = 10'(ri);
    w = -1;
    for (int k = 1; k <= 2 * TD; k++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        w = k;
        break;
      end
    end
    model_tick(ri, exp_sp);
    b = 0; p = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.busy === 1'b1) b++;
      if (bus.spawn_pulse === 1'b1) p++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.crash = 1'b0; bus.randint = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.slot_active !== '0) begin errors++; $display("FAIL reset_active got %h exp 0", bus.slot_active); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", bus.tick); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.spawn_pulse !== 1'b0) begin errors++; $display("FAIL reset_spawn got %b exp 0", bus.spawn_pulse); end
    for (int i = 0; i < NS; i++) begin
      checks++; if (bus.enemy_x[12*i +: 12] !== 12'(XS)) begin errors++; $display("FAIL reset_x[%0d] got %0d exp %0d", i, bus.enemy_x[12*i +: 12], XS); end
      checks++; if (bus.enemy_y[12*i +: 12] !== 12'(YS)) begin errors++; $display("FAIL reset_y[%0d] got %0d exp %0d", i, bus.enemy_y[12*i +: 12], YS); end
    end
  endtask

  task automatic test_first_spawn();
    int w, b, p;
    bit sp;
    model_reset();
    rst = 1'b0;
    run_tick(100, w, b, p, sp);
    checks++; if (w !== TD - 1) begin errors++; $display("FAIL first_tick_cycle got %0d exp %0d", w, TD - 1); end
    checks++; if (b !== NS + 1) begin errors++; $display("FAIL first_busy got %0d exp %0d", b, NS + 1); end
    checks++; if (p !== 0) begin errors++; $display("FAIL first_no_spawn got %0d exp 0", p); end
    run_tick(100, w, b, p, sp);
    checks++; if (w !== TD - 7) begin errors++; $display("FAIL second_tick_gap got %0d exp %0d", w, TD - 7); end
    checks++; if (p !== 1) begin errors++; $display("FAIL first_spawn_pulse got %0d exp 1", p); end
    checks++; if (bus.slot_active !== 4'b0001) begin errors++; $display("FAIL first_spawn_active got %b exp 0001", bus.slot_active); end
    checks++; if (bus.enemy_x[11:0] !== 12'd1180) begin errors++; $display("FAIL first_spawn_x got %0d exp 1180", bus.enemy_x[11:0]); end
    checks++; if (bus.enemy_y[11:0] !== 12'd100) begin errors++; $display("FAIL first_spawn_y got %0d exp 100", bus.enemy_y[11:0]); end
  endtask

  task automatic test_random(input int n);
    int w, b, p, ri;
    bit sp;
    for (int t = 0; t < n; t++) begin
      case ($urandom_range(0, 7))
        0: ri = 0;
        1: ri = 1000;
        2: ri = 1023;
        3: ri = 700;
        default: ri = int'($urandom_range(0, 1023));
      endcase
      run_tick(ri, w, b, p, sp);
      checks++; if (w !== TD - 7) begin errors++; $display("FAIL rnd_tick_gap t%0d got %0d exp %0d", t, w, TD - 7); end
      checks++; if (b !== NS + 1) begin errors++; $display("FAIL rnd_busy t%0d got %0d exp %0d", t, b, NS + 1); end
      checks++; if (p !== int'(sp)) begin errors++; $display("FAIL rnd_spawn t%0d got %0d exp %0d", t, p, sp); end
      for (int i = 0; i < NS; i++) begin
        checks++; if (bus.slot_active[i] !== m_act[i]) begin errors++; $display("FAIL rnd_act t%0d s%0d got %b exp %b", t, i, bus.slot_active[i], m_act[i]); end
        checks++; if (bus.enemy_x[12*i +: 12] !== 12'(m_x[i])) begin errors++; $display("FAIL rnd_x t%0d s%0d got %0d exp %0d", t, i, bus.enemy_x[12*i +: 12], m_x[i]); end
        checks++; if (bus.enemy_y[12*i +: 12] !== 12'(m_y[i])) begin errors++; $display("FAIL rnd_y t%0d s%0d got %0d exp %0d", t, i, bus.enemy_y[12*i +: 12], m_y[i]); end
      end
    end
  endtask

  task automatic test_crash();
    int w, b, p, ticks;
    bit sp, seen;
    seen = 1'b0;
    for (int k = 0; k < 2 * TD && !seen; k++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL crash_pre_tick got timeout exp tick"); end
    @(negedge clk);
    @(negedge clk);
    bus.crash = 1'b1;
    model_slot(0);
    model_freeze();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL crash_busy got %b exp 0", bus.busy); end
    for (int i = 0; i < NS; i++) begin
      checks++; if (bus.slot_active[i] !== 1'b0) begin errors++; $display("FAIL crash_act s%0d got %b exp 0", i, bus.slot_active[i]); end
      checks++; if (bus.enemy_x[12*i +: 12] !== 12'(m_x[i])) begin errors++; $display("FAIL crash_x s%0d got %0d exp %0d", i, bus.enemy_x[12*i +: 12], m_x[i]); end
      checks++; if (bus.enemy_y[12*i +: 12] !== 12'(m_y[i])) begin errors++; $display("FAIL crash_y s%0d got %0d exp %0d", i, bus.enemy_y[12*i +: 12], m_y[i]); end
    end
    ticks = 0;
    repeat (3 * TD) begin
      @(negedge clk);
      if (bus.tick === 1'b1) ticks++;
    end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL crash_no_tick got %0d exp 0", ticks); end
    bus.crash = 1'b0;
    run_tick(500, w, b, p, sp);
    checks++; if (w !== TD) begin errors++; $display("FAIL crash_release_tick got %0d exp %0d", w, TD); end
    checks++; if (b !== NS + 1) begin errors++; $display("FAIL crash_release_busy got %0d exp %0d", b, NS + 1); end
    checks++; if (p !== int'(sp)) begin errors++; $display("FAIL crash_release_spawn got %0d exp %0d", p, sp); end
    for (int i = 0; i < NS; i++) begin
      checks++; if (bus.slot_active[i] !== m_act[i]) begin errors++; $display("FAIL crash_rel_act s%0d got %b exp %b", i, bus.slot_active[i], m_act[i]); end
      checks++; if (bus.enemy_y[12*i +: 12] !== 12'(m_y[i])) begin errors++; $display("FAIL crash_rel_y s%0d got %0d exp %0d", i, bus.enemy_y[12*i +: 12], m_y[i]); end
    end
  endtask

  task automatic test_rst_mid_update();
    int w, b, p;
    bit sp, seen;
    seen = 1'b0;
    for (int k = 0; k < 2 * TD && !seen; k++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_pre_tick got timeout exp tick"); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.slot_active !== '0) begin errors++; $display("FAIL rstmid_active got %h exp 0", bus.slot_active); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    for (int i = 0; i < NS; i++) begin
      checks++; if (bus.enemy_x[12*i +: 12] !== 12'(XS)) begin errors++; $display("FAIL rstmid_x s%0d got %0d exp %0d", i, bus.enemy_x[12*i +: 12], XS); end
      checks++; if (bus.enemy_y[12*i +: 12] !== 12'(YS)) begin errors++; $display("FAIL rstmid_y s%0d got %0d exp %0d", i, bus.enemy_y[12*i +: 12], YS); end
    end
    model_reset();
    rst = 1'b0;
    run_tick(0, w, b, p, sp);
    checks++; if (w !== TD - 1) begin errors++; $display("FAIL rstmid_tick got %0d exp %0d", w, TD - 1); end
    checks++; if (p !== int'(sp)) begin errors++; $display("FAIL rstmid_spawn got %0d exp %0d", p, sp); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_spawn();
    test_random(700);
    test_crash();
    test_random(30);
    test_rst_mid_update();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
